// File: rtl/etcpu_pckg.sv
// Shared CPU-wide constants and the writeback request type passed between
// the writeback FIFO and the writeback register.
package etcpu_pckg;

   localparam int REG_W     = 5;
   localparam int REG_N     = 32;
   localparam int REG_S     = 32;
   localparam int WB_FIFO_D = 2;

   typedef struct packed {
      logic [REG_W-1:0] wa;
      logic [REG_S-1:0] wd;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback requests. Every slot and its valid bit are
// exposed so the stage can flag hazards against anything still buffered.
module wb_fifo #(
   parameter int DEPTH = etcpu_pckg::WB_FIFO_D,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                push,
   input  etcpu_pckg::wb_req_t                 push_req,
   input  logic                                pop,
   output etcpu_pckg::wb_req_t                 head,
   output logic [CW-1:0]                       count,
   output etcpu_pckg::wb_req_t [DEPTH-1:0]     entries,
   output logic [DEPTH-1:0]                    entry_vld
);
   import etcpu_pckg::*;

   wb_req_t [DEPTH-1:0] mem;
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic                do_push;
   logic                do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Overflowing pushes and underflowing pops are ignored rather than corrupting state.
   assign do_push = push && (count < CW'(DEPTH));
   assign do_pop  = pop && (count != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         entry_vld <= '0;
      end else begin
         if (do_push) begin
            wr_ptr            <= ptr_inc(wr_ptr);
            entry_vld[wr_ptr] <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr            <= ptr_inc(rd_ptr);
            entry_vld[rd_ptr] <= 1'b0;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_req;
      end
   end

   assign head    = mem[rd_ptr];
   assign entries = mem;

endmodule

// File: rtl/regfile_wb.sv
// Writeback stage: merges LSU returns and buffered ALU results onto the
// single regfile write port, and provides decode-side bypass and hazard flag.
module regfile_wb #(
   parameter int REG_W  = etcpu_pckg::REG_W,
   parameter int REG_N  = etcpu_pckg::REG_N,
   parameter int REG_S  = etcpu_pckg::REG_S,
   parameter int FIFO_D = etcpu_pckg::WB_FIFO_D
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_vld,
   output logic             alu_rdy,
   input  logic [REG_W-1:0] alu_wa,
   input  logic [REG_S-1:0] alu_wd,
   input  logic             lsu_vld,
   input  logic [REG_W-1:0] lsu_wa,
   input  logic [REG_S-1:0] lsu_wd,
   output logic             we,
   output logic [REG_W-1:0] wa,
   output logic [REG_S-1:0] wd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [REG_S-1:0] rf_rd1,
   input  logic [REG_S-1:0] rf_rd2,
   output logic [REG_S-1:0] op1,
   output logic [REG_S-1:0] op2,
   output logic             hzd
);
   import etcpu_pckg::*;

   localparam int CW = $clog2(FIFO_D + 1);

   if (FIFO_D < 1 || REG_N > (1 << REG_W)) begin : g_bad_cfg
      $error("regfile_wb: FIFO_D must be >= 1 and REG_N must fit in REG_W bits");
   end

   wb_req_t               alu_req;
   wb_req_t               lsu_req;
   wb_req_t               fifo_head;
   wb_req_t [FIFO_D-1:0]  fifo_entries;
   logic [FIFO_D-1:0]     fifo_vld;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  alu_acc;
   logic                  win_vld;
   wb_req_t               win;

   assign alu_req = '{wa: alu_wa, wd: alu_wd};
   assign lsu_req = '{wa: lsu_wa, wd: lsu_wd};
   assign alu_rdy = rst_n && (fifo_count < CW'(FIFO_D));
   assign alu_acc = alu_vld && alu_rdy;

   wb_fifo #(.DEPTH(FIFO_D)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_req  (alu_req),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .entries   (fifo_entries),
      .entry_vld (fifo_vld)
   );

   // LSU can never be stalled, so it always wins; buffered ALU results come
   // next to preserve ALU order, and only an empty FIFO lets the ALU bypass.
   always_comb begin
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      win_vld   = 1'b0;
      win       = alu_req;
      if (lsu_vld) begin
         win_vld   = 1'b1;
         win       = lsu_req;
         fifo_push = alu_acc;
      end else if (fifo_count != '0) begin
         win_vld   = 1'b1;
         win       = fifo_head;
         fifo_pop  = 1'b1;
         fifo_push = alu_acc;
      end else if (alu_acc) begin
         win_vld   = 1'b1;
         win       = alu_req;
      end
   end

   // Writes to x0 are consumed here so the regfile never sees them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we <= 1'b0;
         wa <= '0;
         wd <= '0;
      end else if (win_vld) begin
         we <= (win.wa != '0);
         wa <= win.wa;
         wd <= win.wd;
      end else begin
         we <= 1'b0;
      end
   end

   assign op1 = (we && (wa == rs1) && (rs1 != '0)) ? wd : rf_rd1;
   assign op2 = (we && (wa == rs2) && (rs2 != '0)) ? wd : rf_rd2;

   function automatic logic rs_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] p1,
                                   input logic [REG_W-1:0] p2);
      return ((p1 != '0) && (p1 == dst)) || ((p2 != '0) && (p2 == dst));
   endfunction

   // Anything accepted but not yet sitting in the wb register is a hazard.
   always_comb begin
      hzd = 1'b0;
      for (int i = 0; i < FIFO_D; i++) begin
         if (fifo_vld[i] && rs_hit(fifo_entries[i].wa, rs1, rs2)) begin
            hzd = 1'b1;
         end
      end
      if (lsu_vld && rs_hit(lsu_wa, rs1, rs2)) begin
         hzd = 1'b1;
      end
      if (alu_acc && rs_hit(alu_wa, rs1, rs2)) begin
         hzd = 1'b1;
      end
   end

endmodule
